pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_hazard_detect.sv | 31 +++
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   state_t        controller state (RUN / LU_STALL)
//   WB_W/M_W/EX_W  widths of the control groups entering ID/EX
//   M_MEMREAD_BIT  position of MemRead inside the M control group
//   REG_W/REG_ZERO register-specifier width and the hardwired-zero register
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } state_t;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 5;

  // M group is {Branch, MemRead, MemWrite}
  localparam int M_MEMREAD_BIT = 1;

  localparam int         REG_W    = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the load held in
// ID/EX and the source registers of the instruction in decode. Kept separate
// so a forwarding unit can reuse the same register compare.
// Ports:
//   i_ex_memread  instruction in ID/EX is a load
//   i_ex_rt       destination register of that load
//   i_id_rs       rs of the decode instruction
//   i_id_rt       rt of the decode instruction
//   i_id_uses_rt  decode instruction actually reads rt
//   o_hazard      decode instruction must wait for the load
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_rt == i_id_rs);
  assign w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);

  // Register zero never carries a real dependency.
  assign o_hazard = i_ex_memread & (i_ex_rt != REG_ZERO) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller for the 5-stage datapath.
// Drives PC / IF/ID write enables, IF/ID flush, ID/EX bubble, EX/MEM flush
// and a whole-pipe hold. Priority: reset, memory busy, taken branch (live or
// pending), load-use stall sequence, normal run.
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating
// stall_cnt / flush_cnt performance counters; otherwise they read as zero.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_id_rs/rt/uses_rt        source operands of the decode instruction
//   id_ex_memread/id_ex_rt     load in ID/EX and its destination
//   branch_taken               branch resolved taken in MEM
//   mem_busy                   data memory wait request
//   pc_write, if_id_write      load enables
//   if_id_flush, id_ex_bubble, ex_mem_flush  control zeroing
//   pipe_hold                  freeze ID/EX, EX/MEM, MEM/WB
//   stall_cnt, flush_cnt       performance counters
//
// state     | meaning
// ST_RUN    | normal issue, hazard check active
// ST_LU_STALL | inserting the remaining load-use bubbles (r_lu_cnt left)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t     r_state;
  logic [1:0] r_lu_cnt;
  logic       r_branch_pend;

  logic w_hazard;
  logic w_stall_ev;
  logic w_flush_ev;

  hazard_detect u_hazard_detect (
    .i_ex_memread (id_ex_memread),
    .i_ex_rt      (id_ex_rt),
    .i_id_rs      (if_id_rs),
    .i_id_rt      (if_id_rt),
    .i_id_uses_rt (if_id_uses_rt),
    .o_hazard     (w_hazard)
  );

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_hold    = 1'b0;
    w_stall_ev   = 1'b0;
    w_flush_ev   = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (branch_taken || r_branch_pend) begin
      // Also covers a branch arriving mid-stall: the stalled instruction
      // is wrong-path, so the stall is simply abandoned.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      w_flush_ev   = 1'b1;
    end else if ((r_state == ST_LU_STALL) || w_hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      w_stall_ev   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_lu_cnt      <= 2'd0;
      r_branch_pend <= 1'b0;
    end else if (mem_busy) begin
      if (branch_taken) begin
        r_branch_pend <= 1'b1;
      end
    end else if (branch_taken || r_branch_pend) begin
      r_branch_pend <= 1'b0;
      r_lu_cnt      <= 2'd0;
      r_state       <= ST_RUN;
    end else if (r_state == ST_LU_STALL) begin
      r_lu_cnt <= r_lu_cnt - 2'd1;
      if (r_lu_cnt == 2'd1) begin
        r_state <= ST_RUN;
      end
    end else if (w_hazard) begin
      // The hazard cycle itself is the first bubble; LU_STALL adds the rest.
      if (LU_STALL_CYCLES > 1) begin
        r_state  <= ST_LU_STALL;
        r_lu_cnt <= 2'(LU_STALL_CYCLES - 1);
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_ev && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_ev && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused_ev;
  assign w_unused_ev = w_stall_ev | w_flush_ev;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       if_id_uses_rt, id_ex_memread, branch_taken, mem_busy;

  logic        d1_pcw, d1_ifw, d1_iff, d1_bub, d1_exf, d1_hold;
  logic [15:0] d1_stall, d1_flush;
  logic        d3_pcw, d3_ifw, d3_iff, d3_bub, d3_exf, d3_hold;
  logic [3:0]  d3_stall, d3_flush;

  logic [5:0] d1_o, d3_o;
  assign d1_o = {d1_pcw, d1_ifw, d1_iff, d1_bub, d1_exf, d1_hold};
  assign d3_o = {d3_pcw, d3_ifw, d3_iff, d3_bub, d3_exf, d3_hold};

  always #5 clk = ~clk;

  pipe_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(d1_pcw), .if_id_write(d1_ifw), .if_id_flush(d1_iff),
    .id_ex_bubble(d1_bub), .ex_mem_flush(d1_exf), .pipe_hold(d1_hold),
    .stall_cnt(d1_stall), .flush_cnt(d1_flush)
  );

  pipe_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(d3_pcw), .if_id_write(d3_ifw), .if_id_flush(d3_iff),
    .id_ex_bubble(d3_bub), .ex_mem_flush(d3_exf), .pipe_hold(d3_hold),
    .stall_cnt(d3_stall), .flush_cnt(d3_flush)
  );

  // output patterns {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold}
  localparam logic [5:0] O_RST   = 6'b001110;
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000100;
  localparam logic [5:0] O_FLUSH = 6'b111110;
  localparam logic [5:0] O_HOLD  = 6'b000001;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] ex_rt;
    logic       br;
    logic       busy;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vt[12];
  int   errors = 0;
  int   checks = 0;

  function automatic int ec(input int v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic mr, input logic [4:0] ert,
                        input logic br, input logic bz);
    rst_n = r; if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = ur;
    id_ex_memread = mr; id_ex_rt = ert; branch_taken = br; mem_busy = bz;
  endtask

  task automatic idle();
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    idle();
  endtask

  task automatic lu_hazard();
    set_in(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
  endtask

  int nb;
  int nh;

  initial begin
    idle();
    rst_n = 1'b0;
    #1;

    vt[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RST,   "rst_c1"};
    vt[1]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RST,   "rst_c2"};
    vt[2]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN,   "post_rst_run"};
    vt[3]  = '{1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, O_STALL, "lu_rs_match"};
    vt[4]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, O_RUN,   "lu_rt_zero"};
    vt[5]  = '{1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, O_STALL, "lu_rt_match"};
    vt[6]  = '{1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, O_RUN,   "lu_rt_unused"};
    vt[7]  = '{1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, O_RUN,   "no_memread"};
    vt[8]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_FLUSH, "branch"};
    vt[9]  = '{1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, O_FLUSH, "branch_over_lu"};
    vt[10] = '{1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, O_HOLD,  "busy_over_lu"};
    vt[11] = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_RUN,   "run_after_busy"};

    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].rst_n, vt[i].rs, vt[i].rt, vt[i].uses_rt, vt[i].memread,
             vt[i].ex_rt, vt[i].br, vt[i].busy);
      #3;
      chk(vt[i].name, int'(d1_o), int'(vt[i].exp));
      if (i == 2) begin
        chk("rst_stall_cnt", int'(d1_stall), 0);
        chk("rst_flush_cnt", int'(d1_flush), 0);
      end
      tick();
    end
    chk("table_stall_cnt", int'(d1_stall), ec(2));
    chk("table_flush_cnt", int'(d1_flush), ec(2));

    // three-cycle load-use stall
    do_reset();
    lu_hazard();
    #3;
    nb = (d3_o == O_STALL) ? 1 : 0;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      #3;
      if (d3_o == O_STALL) nb++;
      if (i == 2) chk("lu3_resume", int'(d3_o), int'(O_RUN));
      tick();
    end
    chk("lu3_bubbles", nb, 3);
    chk("lu3_stall_cnt", int'(d3_stall), ec(3));

    // branch during second of three stall cycles
    do_reset();
    lu_hazard();
    tick();
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    #3;
    chk("br_abort_flush", int'(d3_o), int'(O_FLUSH));
    tick();
    idle();
    #3;
    chk("br_abort_run", int'(d3_o), int'(O_RUN));
    tick();
    chk("br_abort_flush_cnt", int'(d3_flush), ec(1));
    chk("br_abort_stall_cnt", int'(d3_stall), ec(1));

    // memory busy 4 cycles with branch pulsed in cycle 2
    do_reset();
    nh = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, (i == 1), 1'b1);
      #3;
      if (d1_o == O_HOLD) nh++;
      tick();
    end
    chk("busy_hold_cycles", nh, 4);
    chk("busy_no_early_flush", int'(d1_flush), 0);
    idle();
    #3;
    chk("busy_pend_flush", int'(d1_o), int'(O_FLUSH));
    tick();
    #3;
    chk("busy_after_flush", int'(d1_o), int'(O_RUN));
    tick();
    chk("busy_flush_cnt", int'(d1_flush), ec(1));

    // saturation: 20 hazard cycles
    do_reset();
    lu_hazard();
    for (int i = 0; i < 20; i++) tick();
    idle();
    chk("sat_stall_cnt16", int'(d1_stall), ec(20));
    chk("sat_stall_cnt4", int'(d3_stall), ec(15));
    chk("sat_flush_cnt4", int'(d3_flush), 0);

    // reset mid-stall and mid-hold with a pending branch
    do_reset();
    lu_hazard();
    tick();
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #3;
    chk("rst_mid_outputs", int'(d3_o), int'(O_RST));
    tick();
    idle();
    #3;
    chk("rst_mid_stall", int'(d3_o), int'(O_RUN));
    chk("rst_pend_drop", int'(d1_o), int'(O_RUN));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
